vehicle_detect_conditioner: RTL and testbench

//  Upstream stage of the traffic controller core. Conditions raw NS/EW loop-detector inputs into

---
 rtl/traffic_pkg.sv | 12 +
 rtl/vehicle_detect_conditioner_if.sv | 25 ++
 rtl/detect_channel.sv | 95 +++++++++
 rtl/vehicle_detect_conditioner.sv | 40 ++++
 tb/tb_vehicle_detect_conditioner.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared constants and types for the traffic controller's detector conditioning stage.
package traffic_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int STUCK_CYCLES_DEF    = 64;

    typedef enum logic {
        NS = 1'b0,
        EW = 1'b1
    } approach_e;

endpackage

// File: rtl/vehicle_detect_conditioner_if.sv
// Raw detector inputs, served pulses and conditioned presence/call/fault outputs for both approaches.
interface vehicle_detect_conditioner_if;

    logic ns_raw;
    logic ew_raw;
    logic ns_served;
    logic ew_served;
    logic ns_present;
    logic ew_present;
    logic ns_call;
    logic ew_call;
    logic ns_fault;
    logic ew_fault;

    modport master (
        output ns_raw, ew_raw, ns_served, ew_served,
        input  ns_present, ew_present, ns_call, ew_call, ns_fault, ew_fault
    );

    modport slave (
        input  ns_raw, ew_raw, ns_served, ew_served,
        output ns_present, ew_present, ns_call, ew_call, ns_fault, ew_fault
    );

endinterface

// File: rtl/detect_channel.sv
// One approach: 2-flop synchronizer, debounce, service-call latch.
// Optional stuck-on detection with fail-safe recall when STUCK_DETECT_EN is defined.
module detect_channel
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic served,
    output logic present,
    output logic call,
    output logic fault
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || STUCK_CYCLES < 2) begin : g_bad_params
        $error("detect_channel: DEBOUNCE_CYCLES must be >= 1 and STUCK_CYCLES >= 2");
    end

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          rise;
    logic          force_call;

    // Presence rises on this edge exactly when the last disagreeing sample completes a 0->1 run.
    always_comb begin
        rise = s2 & ~present & (cnt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            cnt     <= '0;
            present <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == present) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                present <= s2;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef STUCK_DETECT_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);
    localparam logic [SW-1:0] STUCK_MAX  = SW'(STUCK_CYCLES);
    localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);

    logic [SW-1:0] stuck_cnt;

    // Fault is sticky: only reset clears it, even after presence drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            stuck_cnt <= '0;
            fault     <= 1'b0;
        end else if (!present) begin
            stuck_cnt <= '0;
        end else if (stuck_cnt != STUCK_MAX) begin
            stuck_cnt <= stuck_cnt + 1'b1;
            if (stuck_cnt == STUCK_LAST) begin
                fault <= 1'b1;
            end
        end
    end

    assign force_call = fault;
`else
    assign fault      = 1'b0;
    assign force_call = 1'b0;
`endif

    // A new arrival beats a simultaneous served pulse; a faulted detector keeps recalling.
    always_ff @(posedge clk) begin
        if (rst) begin
            call <= 1'b0;
        end else if (rise || force_call) begin
            call <= 1'b1;
        end else if (served) begin
            call <= 1'b0;
        end
    end

endmodule

// File: rtl/vehicle_detect_conditioner.sv
// Conditions raw NS/EW loop detectors into presence levels and latched service calls.
// Build option: define STUCK_DETECT_EN to enable stuck-on fault detection and fail-safe recall.
module vehicle_detect_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    vehicle_detect_conditioner_if.slave   bus
);

    detect_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_ns (
        .clk     (clk),
        .rst     (rst),
        .raw     (bus.ns_raw),
        .served  (bus.ns_served),
        .present (bus.ns_present),
        .call    (bus.ns_call),
        .fault   (bus.ns_fault)
    );

    detect_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_ew (
        .clk     (clk),
        .rst     (rst),
        .raw     (bus.ew_raw),
        .served  (bus.ew_served),
        .present (bus.ew_present),
        .call    (bus.ew_call),
        .fault   (bus.ew_fault)
    );

endmodule

// File: tb/tb_vehicle_detect_conditioner.sv
// Directed bench for vehicle_detect_conditioner with DEBOUNCE_CYCLES=4, STUCK_CYCLES=16.
// Exercises the STUCK_DETECT_EN branch when that macro is defined for the build.
module tb_vehicle_detect_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checkCount = 0;
    int   errorCount = 0;

    vehicle_detect_conditioner_if bus ();

    vehicle_detect_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .STUCK_CYCLES    (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic actual, input logic expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
        end
    endtask

    // Drive inputs, then advance the given number of rising edges; outputs settle 1 time unit after each edge.
    task automatic applyStimulus(input logic nsRaw, input logic ewRaw, input logic nsServed,
                                 input logic ewServed, input int cycles);
        bus.ns_raw    = nsRaw;
        bus.ew_raw    = ewRaw;
        bus.ns_served = nsServed;
        bus.ew_served = ewServed;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3);
        rst = 1'b0;
    endtask

    initial begin
        logic seenPresent;
        logic seenCall;
        logic toggle;

        bus.ns_raw    = 1'b0;
        bus.ew_raw    = 1'b0;
        bus.ns_served = 1'b0;
        bus.ew_served = 1'b0;
        @(negedge clk);

        $display("[TB] reset with ns_raw held high");
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3);
        checkOutput("rst_ns_present", bus.ns_present, 1'b0);
        checkOutput("rst_ew_present", bus.ew_present, 1'b0);
        checkOutput("rst_ns_call",    bus.ns_call,    1'b0);
        checkOutput("rst_ew_call",    bus.ew_call,    1'b0);
        checkOutput("rst_ns_fault",   bus.ns_fault,   1'b0);
        checkOutput("rst_ew_fault",   bus.ew_fault,   1'b0);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5);
        checkOutput("rel_e5_present", bus.ns_present, 1'b0);
        checkOutput("rel_e5_call",    bus.ns_call,    1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("rel_e6_present", bus.ns_present, 1'b1);
        checkOutput("rel_e6_call",    bus.ns_call,    1'b1);

        $display("[TB] glitching ns_raw");
        applyReset();
        seenPresent = 1'b0;
        seenCall    = 1'b0;
        toggle      = 1'b0;
        for (int i = 0; i < 50; i++) begin
            toggle = ~toggle;
            applyStimulus(toggle, 1'b0, 1'b0, 1'b0, 1);
            seenPresent = seenPresent | bus.ns_present;
            seenCall    = seenCall | bus.ns_call;
        end
        checkOutput("glitch_present", seenPresent, 1'b0);
        checkOutput("glitch_call",    seenCall,    1'b0);

        $display("[TB] pulse width");
        applyReset();
        seenPresent = 1'b0;
        for (int i = 0; i < 13; i++) begin
            applyStimulus((i < 3) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0, 1);
            seenPresent = seenPresent | bus.ns_present;
        end
        checkOutput("short_pulse_present", seenPresent, 1'b0);
        checkOutput("short_pulse_call",    bus.ns_call,  1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5);
        checkOutput("pulse6_e5_present", bus.ns_present, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("pulse6_e6_present", bus.ns_present, 1'b1);
        checkOutput("pulse6_e6_call",    bus.ns_call,    1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5);
        checkOutput("pulse6_hold_present", bus.ns_present, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("pulse6_fall_present", bus.ns_present, 1'b0);
        checkOutput("pulse6_fall_call",    bus.ns_call,    1'b1);

        $display("[TB] service");
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 6);
        checkOutput("svc_call_up", bus.ns_call, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
        checkOutput("svc_call_cleared", bus.ns_call,    1'b0);
        checkOutput("svc_present_held", bus.ns_present, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10);
        checkOutput("svc_no_rerise", bus.ns_call, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6);
        checkOutput("svc_present_low", bus.ns_present, 1'b0);
        checkOutput("svc_call_low",    bus.ns_call,    1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5);
        checkOutput("svc_rearrive_e5", bus.ns_call, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("svc_rearrive_e6", bus.ns_call, 1'b1);

        $display("[TB] served colliding with rise");
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
        checkOutput("coll_ns_present", bus.ns_present, 1'b1);
        checkOutput("coll_ns_call",    bus.ns_call,    1'b1);
        checkOutput("coll_ew_present", bus.ew_present, 1'b0);
        checkOutput("coll_ew_call",    bus.ew_call,    1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3);
        checkOutput("coll_ns_call_hold", bus.ns_call, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1);
        checkOutput("ew_served_idle_ew", bus.ew_call, 1'b0);
        checkOutput("ew_served_keep_ns", bus.ns_call, 1'b1);

        $display("[TB] stuck detector on EW");
        applyReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 6);
        checkOutput("stuck_ew_present", bus.ew_present, 1'b1);
        checkOutput("stuck_ew_call",    bus.ew_call,    1'b1);
        checkOutput("stuck_ew_fault0",  bus.ew_fault,   1'b0);
`ifdef STUCK_DETECT_EN
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 15);
        checkOutput("stuck_e15_fault", bus.ew_fault, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
        checkOutput("stuck_e16_fault", bus.ew_fault, 1'b1);
        checkOutput("stuck_ns_fault",  bus.ns_fault, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1);
        checkOutput("stuck_served_call", bus.ew_call, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10);
        checkOutput("stuck_sticky_fault", bus.ew_fault,   1'b1);
        checkOutput("stuck_sticky_call",  bus.ew_call,    1'b1);
        checkOutput("stuck_present_gone", bus.ew_present, 1'b0);
        applyReset();
        checkOutput("stuck_rst_fault", bus.ew_fault, 1'b0);
        checkOutput("stuck_rst_call",  bus.ew_call,  1'b0);
`else
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 100);
        checkOutput("nostuck_ew_fault", bus.ew_fault, 1'b0);
        checkOutput("nostuck_ns_fault", bus.ns_fault, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1);
        checkOutput("nostuck_served_call", bus.ew_call, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
